// File: rtl/ula_pkg.sv
// ula_pkg: opcodes, writeback sources and FSM states shared by the ULA sequencer
package ula_pkg;
  localparam logic [3:0] OP_LD = 4'b0000, OP_ST = 4'b0001, OP_MVNZ = 4'b0010, OP_MV = 4'b0011,
                         OP_MVI = 4'b0100, OP_ADD = 4'b0101, OP_SUB = 4'b0110, OP_OR = 4'b0111,
                         OP_SLT = 4'b1000, OP_SLL = 4'b1001, OP_SRL = 4'b1010;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_REG = 2'd2, WB_IMM = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEMW, S_IMMW, S_WB, S_FIN} state_t;
endpackage

// File: rtl/ula_wait_timer.sv
// ula_wait_timer: response wait counter (clock, resetn, clr, en in; expire out, high on the MAX-th enabled cycle)
module ula_wait_timer #(
  parameter int MAX = 15
)(
  input  logic clock,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [7:0] LAST = 8'(MAX - 1);
  logic [7:0] cnt;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 8'd1 : cnt;
  assign expire = en && cnt == LAST;
endmodule

// File: rtl/ula_sequencer.sv
// ula_sequencer: multi-cycle control FSM (run/instr/nz/mem_ready/imm_valid in; ula_op, sel_x/y, wb_src, reg_write, mem_read/write, imm_req, busy, done, error out)
module ula_sequencer import ula_pkg::*; #(
  parameter int OP_W = 4,
  parameter int REG_AW = 3,
  parameter int MEM_TIMEOUT = 15
)(
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic [15:0]       instr,
  input  logic              nz,
  input  logic              mem_ready,
  input  logic              imm_valid,
  output logic [OP_W-1:0]   ula_op,
  output logic [REG_AW-1:0] sel_x,
  output logic [REG_AW-1:0] sel_y,
  output logic [1:0]        wb_src,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              imm_req,
  output logic              busy,
  output logic              done,
  output logic              error
);
  state_t state;
  logic [15:6] ir;
  logic [3:0] op;
  logic expire;
  assign op = ir[15:12];
  assign ula_op = state == S_IDLE ? '0 : ir[15 -: OP_W];
  assign sel_x = state == S_IDLE ? '0 : ir[11 -: REG_AW];
  assign sel_y = state == S_IDLE ? '0 : ir[8 -: REG_AW];
  ula_wait_timer #(.MAX(MEM_TIMEOUT)) u_timer (
    .clock (clock),
    .resetn(resetn),
    .clr   (state == S_DECODE),
    .en    (state == S_MEMW || state == S_IMMW),
    .expire(expire)
  );
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state     <= S_IDLE;
      ir        <= '0;
      busy      <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      imm_req   <= 1'b0;
      wb_src    <= WB_ALU;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      imm_req   <= 1'b0;
      wb_src    <= WB_ALU;
      done      <= 1'b0;
      error     <= 1'b0;
      case (state)
        S_IDLE:
          if (run) begin
            ir    <= instr[15:6];
            state <= S_DECODE;
            busy  <= 1'b1;
          end
        S_DECODE:
          case (op)
            OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SRL: state <= S_EXEC;
            OP_LD: begin
              state    <= S_MEMW;
              mem_read <= 1'b1;
            end
            OP_ST: begin
              state     <= S_MEMW;
              mem_write <= 1'b1;
            end
            OP_MVI: begin
              state   <= S_IMMW;
              imm_req <= 1'b1;
            end
            OP_MV, OP_MVNZ: begin
              state     <= S_WB;
              reg_write <= op == OP_MV || nz;
              wb_src    <= WB_REG;
            end
            default: begin
              state <= S_FIN;
              done  <= 1'b1;
              error <= 1'b1;
            end
          endcase
        S_EXEC: begin
          state     <= S_WB;
          reg_write <= 1'b1;
        end
        S_MEMW:
          if (mem_ready) begin
            state     <= op == OP_LD ? S_WB : S_FIN;
            reg_write <= op == OP_LD;
            wb_src    <= op == OP_LD ? WB_MEM : WB_ALU;
            done      <= op != OP_LD;
          end else if (expire) begin
            state <= S_FIN;
            done  <= 1'b1;
            error <= 1'b1;
          end else begin
            mem_read  <= mem_read;
            mem_write <= mem_write;
          end
        S_IMMW:
          if (imm_valid) begin
            state     <= S_WB;
            reg_write <= 1'b1;
            wb_src    <= WB_IMM;
          end else if (expire) begin
            state <= S_FIN;
            done  <= 1'b1;
            error <= 1'b1;
          end else imm_req <= 1'b1;
        S_WB: begin
          state <= S_FIN;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_ula_sequencer.sv
// tb_ula_sequencer: randomized self-checking bench for ula_sequencer against a latency/behaviour model
module tb_ula_sequencer;
  localparam int MEM_TIMEOUT = 15;
  logic clock = 1'b0, resetn = 1'b0, run = 1'b0, nz = 1'b0, mem_ready = 1'b0, imm_valid = 1'b0;
  logic [15:0] instr = '0;
  logic [3:0] ula_op;
  logic [2:0] sel_x, sel_y;
  logic [1:0] wb_src;
  logic reg_write, mem_read, mem_write, imm_req, busy, done, error;
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  ula_sequencer #(.OP_W(4), .REG_AW(3), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .resetn(resetn), .run(run), .instr(instr), .nz(nz), .mem_ready(mem_ready),
    .imm_valid(imm_valid), .ula_op(ula_op), .sel_x(sel_x), .sel_y(sel_y), .wb_src(wb_src),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .imm_req(imm_req),
    .busy(busy), .done(done), .error(error)
  );
  function automatic logic [18:0] outs();
    return {ula_op, sel_x, sel_y, wb_src, reg_write, mem_read, mem_write, imm_req, busy, done, error};
  endfunction
  task automatic exec_op(input logic [15:0] ins, input logic nzv, input int dly);
    logic [3:0] op;
    int exp_done, exp_wr, exp_req, done_c, wr_c, req_c, bad;
    logic exp_err, err_o;
    logic [1:0] exp_wb, wb_o;
    op = ins[15:12];
    exp_err = 1'b0; exp_wr = -1; exp_wb = 2'd0; exp_req = 0;
    if (op >= 4'd5 && op <= 4'd10) begin exp_done = 4; exp_wr = 3; exp_wb = 2'd0; end
    else if (op == 4'd2 || op == 4'd3) begin exp_done = 3; exp_wr = (op == 4'd3 || nzv) ? 2 : -1; exp_wb = 2'd2; end
    else if (op >= 4'd11) begin exp_done = 2; exp_err = 1'b1; end
    else if (dly >= MEM_TIMEOUT) begin exp_req = MEM_TIMEOUT; exp_done = 2 + MEM_TIMEOUT; exp_err = 1'b1; end
    else begin
      exp_req = dly + 1;
      if (op == 4'd1) exp_done = 3 + dly;
      else begin exp_wr = 3 + dly; exp_done = 4 + dly; exp_wb = (op == 4'd0) ? 2'd1 : 2'd3; end
    end
    done_c = -1; wr_c = -1; req_c = 0; bad = 0; err_o = 1'b0; wb_o = 2'd0;
    instr = ins; nz = nzv; run = 1'b1;
    @(negedge clock);
    run = 1'b0; instr = 16'($urandom);
    for (int k = 1; k <= 40 && done_c < 0; k++) begin
      if (!busy || ula_op !== op || sel_x !== ins[11:9] || sel_y !== ins[8:6]) bad++;
      if ($countones({reg_write, mem_read, mem_write, imm_req}) > 1) bad++;
      if ((mem_read && op != 4'd0) || (mem_write && op != 4'd1) || (imm_req && op != 4'd4)) bad++;
      if (error && !done) bad++;
      if (mem_read || mem_write || imm_req) req_c++;
      mem_ready = (mem_read || mem_write) && req_c == dly + 1;
      imm_valid = imm_req && req_c == dly + 1;
      if (reg_write) begin
        if (wr_c < 0) wr_c = k; else bad++;
        wb_o = wb_src;
      end
      if (done) begin done_c = k; err_o = error; end
      @(negedge clock);
    end
    mem_ready = 1'b0; imm_valid = 1'b0;
    checks++; if (done_c !== exp_done) begin errors++; $display("FAIL done_cycle instr=%h got %0d want %0d", ins, done_c, exp_done); end
    checks++; if (err_o !== exp_err) begin errors++; $display("FAIL error instr=%h got %b want %b", ins, err_o, exp_err); end
    checks++; if (wr_c !== exp_wr) begin errors++; $display("FAIL write_cycle instr=%h nz=%b got %0d want %0d", ins, nzv, wr_c, exp_wr); end
    checks++; if (req_c !== exp_req) begin errors++; $display("FAIL req_cycles instr=%h dly=%0d got %0d want %0d", ins, dly, req_c, exp_req); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL protocol instr=%h got %0d violations want 0", ins, bad); end
    if (exp_wr >= 0) begin
      checks++; if (wb_o !== exp_wb) begin errors++; $display("FAIL wb_src instr=%h got %0d want %0d", ins, wb_o, exp_wb); end
    end
    checks++; if (outs() !== 19'd0) begin errors++; $display("FAIL idle_outputs instr=%h got %h want 0", ins, outs()); end
  endtask
  task automatic test_reset();
    #3;
    checks++; if (outs() !== 19'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs()); end
    @(negedge clock); resetn = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_without_run busy got %b want 0", busy); end
  endtask
  task automatic test_alu();
    exec_op(16'h5280, 1'b0, 0);
    for (int i = 0; i < 8; i++) exec_op({4'($urandom_range(5, 10)), 12'($urandom)}, 1'($urandom), 0);
  endtask
  task automatic test_mem();
    exec_op(16'h0280, 1'b0, 3);
    exec_op(16'h1440, 1'b0, 0);
    exec_op(16'h4E00, 1'b0, 2);
    exec_op(16'h1000, 1'b0, 100);
    exec_op(16'h1000, 1'b0, MEM_TIMEOUT - 1);
    exec_op(16'h0A00, 1'b0, MEM_TIMEOUT);
    exec_op(16'h4200, 1'b0, MEM_TIMEOUT - 1);
    exec_op(16'h4200, 1'b0, 200);
  endtask
  task automatic test_moves();
    exec_op(16'h2280, 1'b0, 0);
    exec_op(16'h2280, 1'b1, 0);
    exec_op(16'h3A40, 1'b0, 0);
  endtask
  task automatic test_illegal();
    exec_op(16'hF000, 1'b0, 0);
    for (int i = 0; i < 4; i++) exec_op({4'($urandom_range(11, 15)), 12'($urandom)}, 1'b1, 0);
  endtask
  task automatic test_back_to_back();
    int bad;
    bad = 0;
    instr = 16'h5280; run = 1'b1;
    @(negedge clock);
    instr = 16'h6A40;
    for (int k = 1; k <= 4; k++) begin
      if (ula_op !== 4'd5 || sel_x !== 3'd1 || !busy) bad++;
      @(negedge clock);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_first_stable got %0d violations want 0", bad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap busy got %b want 0", busy); end
    @(negedge clock);
    run = 1'b0;
    checks++; if ({busy, ula_op, sel_x} !== {1'b1, 4'd6, 3'd5}) begin errors++; $display("FAIL b2b_second got %b/%h/%h want 1/6/5", busy, ula_op, sel_x); end
    for (int i = 0; i < 10 && busy; i++) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_finish busy got %b want 0", busy); end
  endtask
  task automatic test_reset_mid();
    instr = 16'h1000; run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL mid_memw mem_write got %b want 1", mem_write); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (outs() !== 19'd0) begin errors++; $display("FAIL async_reset got %h want 0", outs()); end
    @(negedge clock); resetn = 1'b1;
    @(negedge clock);
    exec_op(16'h5280, 1'b0, 0);
  endtask
  task automatic test_random();
    for (int i = 0; i < 30; i++) exec_op(16'($urandom), 1'($urandom), int'($urandom_range(0, 20)));
  endtask
  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_moves();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ula_sequencer.md
Name: ula_sequencer

Overview:
- Multi-cycle control unit that sequences the 16-bit ALU, register file and memory port for one instruction per Run request.
- Latches the instruction word, decodes the 4-bit opcode, drives ALU opcode and register selects, handles memory/immediate handshakes, and pulses Done on completion.
- Sits between the instruction source and the datapath.

Parameters:
- OP_W, 4, opcode width (Instr[15:12]).
- REG_AW, 3, register address width (Rx = Instr[11:9], Ry = Instr[8:6]).
- MEM_TIMEOUT, 15, max cycles waiting for MemReady or ImmValid before abort (1..255).

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous active-low reset.
- Run  in  1  start request, sampled only in IDLE.
- Instr  in  16  instruction word, sampled on the accepted Run cycle.
- NZ  in  1  datapath flag: the value read on Ry is non-zero (for MVNZ).
- MemReady  in  1  memory completion for LD/ST.
- ImmValid  in  1  immediate word present on the datapath bus (MVI).
- ULAOp  out  4  ALU opcode, equal to the latched opcode.
- SelX  out  3  register-file read/write address Rx.
- SelY  out  3  register-file read address Ry.
- WbSrc  out  2  writeback source: 0 ALU, 1 memory, 2 Ry, 3 immediate.
- RegWrite  out  1  write Rx this cycle.
- MemRead  out  1  LD request, held until MemReady or timeout.
- MemWrite  out  1  ST request, held until MemReady or timeout.
- ImmReq  out  1  MVI immediate request.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  one-cycle pulse on illegal opcode or timeout, coincident with Done.

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE; IR, timeout counter and all outputs go to 0.
- States: IDLE, DECODE, EXEC, MEMW, IMMW, WB, FIN.
- IDLE + Run=1: latch Instr into IR, go to DECODE.
- IDLE + Run=0: stay in IDLE.
- Run outside IDLE is ignored; there is no queueing.
- ULAOp, SelX and SelY are combinational from IR. They are stable from DECODE until FIN and are 0 in IDLE.
- DECODE: register reads settle. Next state by opcode:
  - 0101..1010 (ADD, SUB, OR, SLT, SLL, SRL) -> EXEC.
  - 0000 LD, 0001 ST -> MEMW.
  - 0100 MVI -> IMMW.
  - 0010 MVNZ, 0011 MV -> WB.
  - 1011..1111 -> FIN with Error.
- EXEC: one cycle for the ALU result to settle, then WB with WbSrc=0.
- MEMW: MemRead (LD) or MemWrite (ST) held high.
  - MemReady=1: LD goes to WB with WbSrc=1; ST goes to FIN with no register write.
- IMMW: ImmReq held high. ImmValid=1 -> WB with WbSrc=3.
- Timeout (MEMW/IMMW): counter clears on entry and increments each waiting cycle. When it reaches MEM_TIMEOUT with no response, drop the request and go to FIN with Error; no write.
- If MemReady/ImmValid arrives in the same cycle the counter reaches MEM_TIMEOUT, the response wins.
- WB: RegWrite=1 for exactly one cycle to address SelX.
  - MV: WbSrc=2.
  - MVNZ: WbSrc=2 and RegWrite=NZ. With NZ=0 there is no write, but the same timing applies.
- FIN: Done=1 for one cycle, then IDLE. A new Run is accepted the cycle after FIN.
- Latency from the Run cycle (c0) to the Done cycle:
  - ALU ops: c4.
  - MV/MVNZ: c3.
  - LD/MVI: c4 + response wait cycles.
  - ST: c3 + wait cycles.
  - Illegal opcode: c2.
- RegWrite, MemRead, MemWrite and ImmReq are never asserted together. All are 0 in IDLE, DECODE, EXEC and FIN.

Decomposition:
- Shared package ula_pkg holds:
  - Opcode constants OP_LD..OP_SRL (4'b0000..4'b1010), matching the ALU encoding.
  - WbSrc constants WB_ALU, WB_MEM, WB_REG, WB_IMM.
  - State enumeration.
- One sub-module, ula_wait_timer: counter with clear, enable and expire output, used by MEMW and IMMW.

Test Plan:
- Instr=16'h5280 (ADD R1,R2), Run pulse at c0 -> Busy c1..c4; ULAOp=4'b0101, SelX=1, SelY=2; RegWrite+WbSrc=0 at c3; Done at c4.
- Instr=16'h0280 (LD R1,[R2]), MemReady raised 3 cycles after MemRead -> MemRead high 4 cycles; RegWrite with WbSrc=1 the next cycle, then Done; Error=0.
- MVNZ (Instr=16'h2280) with NZ=0 -> RegWrite never asserted; Done at c3. Repeat with NZ=1 -> RegWrite at c2 with WbSrc=2.
- Instr=16'hF000 -> Done and Error together at c2; no RegWrite, MemRead, MemWrite or ImmReq.
- ST with MemReady held 0, MEM_TIMEOUT=15 -> MemWrite drops after 15 cycles; Done+Error pulse; then IDLE.
- Run held high during an ADD, with Instr changed mid-op -> second instruction accepted only after Done; ULAOp unchanged mid-op.
- Resetn low during MEMW -> all outputs 0 immediately, without waiting for a clock edge; Busy=0; after release, the next Run executes normally.
